// File: rtl/out_stretch.sv
// Multi-channel pulse stretcher: debounce, edge detect, HOLD/GAP FSM with a one-deep event queue.
// Define OUT_STRETCH_SYNC_EN to put a 2-flop synchronizer on every evt_in bit.
module out_stretch #(
  parameter int CH          = 4,
  parameter int HOLD_CYCLES = 8191,
  parameter int GAP_CYCLES  = 1024,
  parameter int DEB_CYCLES  = 16,
  parameter bit RST_PULSE   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] evt_in,
  input  logic          clr_ovf,
  output logic [CH-1:0] pulse_out,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int MaxCyc = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CntW   = $clog2(MaxCyc + 1);
  localparam int DebW   = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [DebW-1:0] DebLast  = (DEB_CYCLES > 0) ? DebW'(DEB_CYCLES - 1) : '0;
  localparam state_e          RstState = RST_PULSE ? HOLD : IDLE;

  logic [CH-1:0] src;
  logic [CH-1:0] samp_q;

`ifdef OUT_STRETCH_SYNC_EN
  logic [CH-1:0] sync1_q;
  logic [CH-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= evt_in;
      sync2_q <= sync1_q;
    end
  end

  assign src = sync2_q;
`else
  assign src = evt_in;
`endif

  // The sample register keeps pulse_out free of any combinational path from evt_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
    end else begin
      samp_q <= src;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [DebW-1:0] deb_cnt_q;
    logic [DebW-1:0] deb_cnt_d;
    logic            f_q;
    logic            f_d;
    logic            f_prev_q;
    logic            evt;
    state_e          state_q;
    state_e          state_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            pend_q;
    logic            pend_d;
    logic            pend_eff;
    logic            ovf_q;
    logic            ovf_d;
    logic            ovf_set;
    logic            pulse_q;

    // The filtered level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
      deb_cnt_d = '0;
      f_d       = f_q;
      if (DEB_CYCLES == 0) begin
        f_d = samp_q[g];
      end else if (samp_q[g] != f_q) begin
        if (deb_cnt_q == DebLast) begin
          f_d = samp_q[g];
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
    end

    assign evt = f_q & ~f_prev_q;

    // An event arriving in the last GAP cycle is folded into pend_eff so the following HOLD serves it.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ovf_set  = 1'b0;
      pend_eff = pend_q;
      if (evt && (state_q != IDLE)) begin
        if (pend_q) begin
          ovf_set = 1'b1;
        end else begin
          pend_eff = 1'b1;
        end
      end
      pend_d = pend_eff;

      case (state_q)
        IDLE: begin
          if (evt) begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
        HOLD: begin
          if (cnt_q == HoldLast) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == GapLast) begin
            cnt_d   = '0;
            pend_d  = 1'b0;
            state_d = pend_eff ? HOLD : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      if (ovf_set) begin
        ovf_d = 1'b1;
      end else if (clr_ovf) begin
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt_q <= '0;
        f_q       <= 1'b0;
        f_prev_q  <= 1'b0;
        state_q   <= RstState;
        cnt_q     <= '0;
        pend_q    <= 1'b0;
        ovf_q     <= 1'b0;
        pulse_q   <= RST_PULSE;
      end else begin
        deb_cnt_q <= deb_cnt_d;
        f_q       <= f_d;
        f_prev_q  <= f_q;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        pend_q    <= pend_d;
        ovf_q     <= ovf_d;
        pulse_q   <= (state_d == HOLD);
      end
    end

    assign pulse_out[g] = pulse_q;
    assign busy[g]      = (state_q != IDLE) | pend_q;
    assign ovf[g]       = ovf_q;
  end

endmodule

// File: tb/tb_out_stretch.sv
// Scoreboard bench for out_stretch: a timeline reference model pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_out_stretch;

  localparam int CH   = 2;
  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int DEB  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_ovf;
  logic [CH-1:0] evt_in;
  logic [CH-1:0] pulse_out;
  logic [CH-1:0] busy;
  logic [CH-1:0] ovf;

  always #5 clk = ~clk;

  out_stretch #(
    .CH(CH),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAP),
    .DEB_CYCLES(DEB),
    .RST_PULSE(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .evt_in(evt_in),
    .clr_ovf(clr_ovf),
    .pulse_out(pulse_out),
    .busy(busy),
    .ovf(ovf)
  );

  int checks = 0;
  int errors = 0;
  bit monOn = 1'b0;
  logic [3*CH-1:0] expQ[$];

  // Reference model state, in absolute edge numbers counted from reset release.
  int t;
  bit rawBuf[CH][16];
  bit fBuf[CH][16];
  int start[CH];
  int holdEnd[CH];
  int gapEnd[CH];
  bit pend[CH];
  bit mOvf[CH];

  function automatic bit rawAt(int c, int i);
    return (i < 0) ? 1'b0 : rawBuf[c][i % 16];
  endfunction

  function automatic bit fAt(int c, int i);
    return (i < 0) ? 1'b0 : fBuf[c][i % 16];
  endfunction

  task automatic modelReset();
    t = 0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 16; k++) begin
        rawBuf[c][k] = 1'b0;
        fBuf[c][k]   = 1'b0;
      end
      start[c]   = 0;
      holdEnd[c] = HOLD;
      gapEnd[c]  = HOLD + GAP;
      pend[c]    = 1'b0;
      mOvf[c]    = 1'b0;
    end
  endtask

  task automatic modelStep();
    bit prevF;
    bit allDiff;
    bit ev;
    bit active;
    bit setOvf;
    t++;
    for (int c = 0; c < CH; c++) begin
      rawBuf[c][t % 16] = evt_in[c];
      prevF   = fAt(c, t - 1);
      allDiff = 1'b1;
      for (int k = 1; k <= DEB; k++) begin
        if (rawAt(c, t - k) == prevF) allDiff = 1'b0;
      end
      fBuf[c][t % 16] = allDiff ? !prevF : prevF;

      ev     = fAt(c, t - 1) && !fAt(c, t - 2);
      active = (t <= gapEnd[c]);
      setOvf = 1'b0;
      if (ev && !active) begin
        start[c]   = t;
        holdEnd[c] = t + HOLD;
        gapEnd[c]  = t + HOLD + GAP;
      end else if (ev) begin
        if (pend[c]) setOvf = 1'b1;
        else pend[c] = 1'b1;
      end
      if (active && (t == gapEnd[c]) && pend[c]) begin
        start[c]   = t;
        holdEnd[c] = t + HOLD;
        gapEnd[c]  = t + HOLD + GAP;
        pend[c]    = 1'b0;
      end
      if (setOvf) mOvf[c] = 1'b1;
      else if (clr_ovf) mOvf[c] = 1'b0;
    end
  endtask

  function automatic logic [3*CH-1:0] expVec();
    logic [CH-1:0] p;
    logic [CH-1:0] b;
    logic [CH-1:0] o;
    for (int c = 0; c < CH; c++) begin
      p[c] = (t >= start[c]) && (t < holdEnd[c]);
      b[c] = (t < gapEnd[c]) || pend[c];
      o[c] = mOvf[c];
    end
    return {p, b, o};
  endfunction

  // Model advances on the same events as the DUT and queues the expected outputs.
  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
      expQ.push_back(expVec());
    end
  end

  task automatic checkOutput(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0d (%0t): got %b, expected %b", name, t, $time, act, exp);
    end
  endtask

  // Monitor: entries superseded within one cycle (reset assertion) are discarded.
  initial begin
    logic [3*CH-1:0] e;
    forever begin
      @(negedge clk);
      if (monOn) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_empty at %0t: got no entry, expected one", $time);
        end else begin
          while (expQ.size() > 1) void'(expQ.pop_front());
          e = expQ.pop_front();
          checkOutput("pulse_out", pulse_out, e[3*CH-1:2*CH]);
          checkOutput("busy", busy, e[2*CH-1:CH]);
          checkOutput("ovf", ovf, e[CH-1:0]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [CH-1:0] ev, input logic clr, input int n);
    evt_in  = ev;
    clr_ovf = clr;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [CH-1:0] rv;
    rst_n   = 1'b0;
    evt_in  = '0;
    clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    monOn = 1'b1;
    applyStimulus(2'b00, 1'b0, 2);
    rst_n = 1'b1;
    applyStimulus(2'b00, 1'b0, 16);

    // Clean held event on ch0
    applyStimulus(2'b01, 1'b0, 20);
    applyStimulus(2'b00, 1'b0, 10);

    // Two-cycle glitch on ch1
    applyStimulus(2'b10, 1'b0, 2);
    applyStimulus(2'b00, 1'b0, 12);

    // Three events on ch0 in quick succession, then clear ovf
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 1'b0, 3);
      applyStimulus(2'b00, 1'b0, 3);
    end
    applyStimulus(2'b00, 1'b0, 30);
    applyStimulus(2'b00, 1'b1, 1);
    applyStimulus(2'b00, 1'b0, 5);

    // Reset mid-HOLD with an event pending
    applyStimulus(2'b01, 1'b0, 3);
    applyStimulus(2'b00, 1'b0, 3);
    applyStimulus(2'b01, 1'b0, 3);
    applyStimulus(2'b00, 1'b0, 1);
    rst_n = 1'b0;
    applyStimulus(2'b00, 1'b0, 2);
    rst_n = 1'b1;
    applyStimulus(2'b00, 1'b0, 20);

    // Simultaneous events on both channels
    applyStimulus(2'b11, 1'b0, 6);
    applyStimulus(2'b00, 1'b0, 20);

    // Random traffic with occasional clears and resets
    rv = '0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 4) == 0) rv[c] = ~rv[c];
      end
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        applyStimulus(rv, 1'b0, 2);
        rst_n = 1'b1;
      end
      applyStimulus(rv, ($urandom_range(0, 15) == 0), 1);
    end
    applyStimulus(2'b00, 1'b0, 20);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_stretch.md
# out_stretch

Multi-channel pulse stretcher that drives event lines toward the Raspberry Pi Zero over the jumper wires. It generalises the existing reset-notification pulse in four ways:
- any number of channels;
- an input debounce filter;
- a guaranteed low gap between pulses;
- a one-deep event queue with overflow reporting.

It sits between the FPGA event sources (buttons, core status strobes) and the output pins. Every asserted output stays high long enough for the Pi to sample it.

## Interface
- CH, 4, number of independent channels (≥1)
- HOLD_CYCLES, 8191, cycles each output pulse stays high (≥1)
- GAP_CYCLES, 1024, minimum low cycles after each pulse (≥1)
- DEB_CYCLES, 16, consecutive stable samples needed to accept an input change (0 = no filter)
- RST_PULSE, 1, 1 = every channel emits one pulse after reset release
- clk  input  1  internal 100 MHz clock
- rst_n  input  1  asynchronous, active-low reset
- evt_in  input  CH  raw event levels; a rising edge of the filtered level is an event
- clr_ovf  input  1  synchronous clear of all ovf bits
- pulse_out  output  CH  stretched pulses to the Pi pins
- busy  output  CH  channel in HOLD or GAP, or holding a pending event
- ovf  output  CH  sticky flag: an event was dropped

## Operation
- Per channel, the stages are: optional synchronizer, then debounce, then edge detect, then FSM. Channels are fully independent.
- Debounce:
  - Filtered level f (reset 0) takes the value of the sample only after the sample has differed from f for DEB_CYCLES consecutive cycles.
  - Any matching sample resets the counter.
  - DEB_CYCLES=0: f is the sample registered once.
- Event: f goes 0→1, detected against a registered copy of f.
- FSM states are IDLE, HOLD and GAP. One shared counter, width $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).
  - IDLE: pulse_out=0. On an event, go to HOLD and clear the counter.
  - HOLD: pulse_out=1 for exactly HOLD_CYCLES cycles, then go to GAP with the counter cleared.
  - GAP: pulse_out=0 for exactly GAP_CYCLES cycles. Then go to HOLD if pending (clearing pending), else to IDLE.
- Events in HOLD or GAP:
  - If pending=0, set pending.
  - If pending=1, drop the event and set ovf.
  - An event in the last GAP cycle becomes pending and is serviced by the HOLD that follows directly.
- ovf:
  - Set has priority over clr_ovf in the same cycle.
  - Otherwise clr_ovf clears every bit.
- busy = (state≠IDLE) | pending, combinational from registers.
- Pulses never merge. Consecutive pulses are always separated by ≥GAP_CYCLES low cycles.

## Timing
- Reset values:
  - state = HOLD and pulse_out = all ones if RST_PULSE=1; otherwise state = IDLE and pulse_out = 0.
  - Counter, pending, ovf, f and the debounce counter: 0.
- rst_n assertion takes effect immediately, mid-operation included.
  - Pending events and in-flight pulses are discarded.
  - With RST_PULSE=1, pulse_out is re-asserted.
- Latency from the first evt_in sample of a clean rising edge to pulse_out rising is DEB_CYCLES+1 cycles (2 with DEB_CYCLES=0). Add 2 cycles with the synchronizer compiled in.
- pulse_out is a direct register output, with no combinational path from evt_in.
- Back-to-back pending service: pulse_out falls, stays low exactly GAP_CYCLES cycles, then rises again.

## Configuration
- OUT_STRETCH_SYNC_EN:
  - Defined: each evt_in bit passes through a 2-flop synchronizer (reset 0) before debounce, and latency increases by 2 cycles.
  - Undefined: evt_in feeds the debounce stage directly. The caller must supply signals synchronous to clk.

## Test plan
All scenarios use CH=2, HOLD_CYCLES=8, GAP_CYCLES=4, DEB_CYCLES=3, RST_PULSE=1, macro undefined.
- Release rst_n with evt_in=0 → required response:
  - pulse_out=2'b11 for 8 cycles, then 2'b00.
  - busy=2'b11 for 12 cycles, then 2'b00.
  - ovf=0.
- evt_in[0] 0→1 held → pulse_out[0] rises 4 cycles after the first high sample, stays high 8 cycles; pulse_out[1] stays 0.
- evt_in[1] high for 2 cycles only (glitch) → no pulse, busy[1]=0 throughout.
- Three clean events on ch0 during one HOLD:
  - The first starts the pulse.
  - The second becomes pending and produces a second 8-cycle pulse after exactly 4 low cycles.
  - The third sets ovf[0]=1.
  - clr_ovf for 1 cycle then gives ovf=0.
- Assert rst_n=0 at HOLD cycle 5 with pending=1 → immediately pulse_out=2'b11 and pending/ovf cleared. After release, exactly one 8-cycle pulse per channel.
- Simultaneous events on both channels in the same cycle → identical, aligned 8-cycle pulses on pulse_out[1:0].
